// File: rtl/ippcsge_anctrl_if.sv
// Receive-side indications from the GE PCS into the auto-negotiation controller:
// sync status plus per-ordered-set RUDI strobe and received config word.
interface ippcsge_anctrl_if;
  logic        sync;
  logic        rudi_vld;
  logic [1:0]  rudi;
  logic [15:0] cfdata;

  modport master (output sync, rudi_vld, rudi, cfdata);
  modport slave  (input  sync, rudi_vld, rudi, cfdata);
endinterface

// File: rtl/ippcsge_anctrl.sv
// 1000BASE-X Clause 37 auto-negotiation controller: tracks RUDI/config-word matches,
// runs the link timer and the AN arbitration FSM, and drives xmit/tx_cfg to the PCS.
module ippcsge_anctrl #(
  parameter int unsigned LINK_TIMER = 1250000,
  parameter int unsigned TMR_W      = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  ippcsge_anctrl_if.slave        rx_if,
  input  logic                   an_enable_i,
  input  logic                   an_restart_i,
  input  logic [15:0]            mr_adv_i,
  output logic [1:0]             xmit_o,
  output logic [15:0]            tx_cfg_o,
  output logic [15:0]            lp_ability_o,
  output logic                   page_rx_o,
  output logic                   an_complete_o,
  output logic [2:0]             an_state_o
);

  typedef enum logic [2:0] {
    AN_ENABLE          = 3'd0,
    AN_RESTART         = 3'd1,
    ABILITY_DETECT     = 3'd2,
    ACK_DETECT         = 3'd3,
    COMPLETE_ACK       = 3'd4,
    IDLE_DETECT        = 3'd5,
    LINK_OK            = 3'd6,
    AN_DISABLE_LINK_OK = 3'd7
  } state_e;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LINK_TIMER - 1);
  localparam logic [15:0]      ACK_BIT  = 16'h4000;

  state_e            state_q, state_d;
  logic [1:0]        cmatch_cnt_q, cmatch_cnt_d;
  logic [1:0]        idle_cnt_q, idle_cnt_d;
  logic [15:0]       prev_cfg_q, prev_cfg_d;
  logic [15:0]       ab_word_q, ab_word_d;
  logic [15:0]       lp_ability_q, lp_ability_d;
  logic [15:0]       tx_cfg_q, tx_cfg_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [1:0]        xmit_q, xmit_d;
  logic              page_rx_q, page_rx_d;
  logic              an_complete_q, an_complete_d;
  logic              page_set, tmr_clr;

  logic              rx_inv, tmr_done, ability_match, ack_match, idle_match, zero_cfg;
  logic [15:0]       prev_masked;

  assign rx_inv        = rx_if.rudi_vld & (rx_if.rudi == 2'b11);
  assign tmr_done      = (tmr_q == TMR_LAST);
  assign prev_masked   = prev_cfg_q & ~ACK_BIT;
  assign ability_match = (cmatch_cnt_q == 2'd3);
  assign ack_match     = ability_match & prev_cfg_q[14];
  assign idle_match    = (idle_cnt_q == 2'd3);
  assign zero_cfg      = ability_match & (prev_masked == 16'h0000);

  // Consecutive-match counters; the ACK bit is ignored when comparing config words.
  always_comb begin
    cmatch_cnt_d = cmatch_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    prev_cfg_d   = prev_cfg_q;
    if (rx_if.rudi_vld) begin
      case (rx_if.rudi)
        2'b01: begin
          if ((rx_if.cfdata & ~ACK_BIT) == prev_masked) begin
            cmatch_cnt_d = (cmatch_cnt_q == 2'd3) ? 2'd3 : cmatch_cnt_q + 2'd1;
          end else begin
            cmatch_cnt_d = 2'd1;
          end
          prev_cfg_d = rx_if.cfdata;
          idle_cnt_d = 2'd0;
        end
        2'b10: begin
          idle_cnt_d   = (idle_cnt_q == 2'd3) ? 2'd3 : idle_cnt_q + 2'd1;
          cmatch_cnt_d = 2'd0;
        end
        2'b11: begin
          idle_cnt_d   = 2'd0;
          cmatch_cnt_d = 2'd0;
        end
        default: begin
          cmatch_cnt_d = cmatch_cnt_q;
        end
      endcase
    end else begin
      cmatch_cnt_d = cmatch_cnt_q;
    end
  end

  // Next-state logic; loss of sync and management restart override every state.
  always_comb begin
    state_d      = state_q;
    tmr_clr      = 1'b0;
    ab_word_d    = ab_word_q;
    lp_ability_d = lp_ability_q;
    page_set     = 1'b0;
    if (!rx_if.sync || an_restart_i) begin
      state_d = AN_ENABLE;
    end else begin
      case (state_q)
        AN_ENABLE: begin
          if (an_enable_i) begin
            state_d = AN_RESTART;
            tmr_clr = 1'b1;
          end else begin
            state_d = AN_DISABLE_LINK_OK;
          end
        end
        AN_RESTART: begin
          if (tmr_done) state_d = ABILITY_DETECT;
          else          state_d = AN_RESTART;
        end
        ABILITY_DETECT: begin
          if (ability_match && !zero_cfg) begin
            state_d   = ACK_DETECT;
            ab_word_d = prev_masked;
          end else begin
            state_d = ABILITY_DETECT;
          end
        end
        ACK_DETECT: begin
          if (zero_cfg) begin
            state_d = AN_ENABLE;
          end else if (ack_match && (prev_masked == ab_word_q)) begin
            state_d      = COMPLETE_ACK;
            tmr_clr      = 1'b1;
            lp_ability_d = prev_cfg_q;
            page_set     = 1'b1;
          end else if (ack_match) begin
            state_d = AN_ENABLE;
          end else begin
            state_d = ACK_DETECT;
          end
        end
        COMPLETE_ACK: begin
          if (zero_cfg) begin
            state_d = AN_ENABLE;
          end else if (tmr_done) begin
            state_d = IDLE_DETECT;
            tmr_clr = 1'b1;
          end else begin
            state_d = COMPLETE_ACK;
          end
        end
        IDLE_DETECT: begin
          if (zero_cfg || rx_inv)         state_d = AN_ENABLE;
          else if (tmr_done && idle_match) state_d = LINK_OK;
          else                            state_d = IDLE_DETECT;
        end
        LINK_OK: begin
          if (ability_match || rx_inv) state_d = AN_ENABLE;
          else                         state_d = LINK_OK;
        end
        AN_DISABLE_LINK_OK: begin
          if (an_enable_i) state_d = AN_ENABLE;
          else             state_d = AN_DISABLE_LINK_OK;
        end
        default: state_d = AN_ENABLE;
      endcase
    end
  end

  assign page_rx_d = (state_d == AN_ENABLE) ? 1'b0 : (page_set ? 1'b1 : page_rx_q);
  assign tmr_d     = tmr_clr ? '0 : (tmr_done ? tmr_q : tmr_q + TMR_W'(1));

  // Output values are a function of the state being entered, so they register alongside it.
  always_comb begin
    xmit_d        = 2'd1;
    tx_cfg_d      = 16'h0000;
    an_complete_d = 1'b0;
    case (state_d)
      ABILITY_DETECT: tx_cfg_d = mr_adv_i & ~ACK_BIT;
      ACK_DETECT,
      COMPLETE_ACK:   tx_cfg_d = mr_adv_i | ACK_BIT;
      IDLE_DETECT: begin
        xmit_d   = 2'd0;
        tx_cfg_d = mr_adv_i | ACK_BIT;
      end
      LINK_OK: begin
        xmit_d        = 2'd2;
        tx_cfg_d      = mr_adv_i | ACK_BIT;
        an_complete_d = 1'b1;
      end
      AN_DISABLE_LINK_OK: xmit_d = 2'd2;
      default: xmit_d = 2'd1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= AN_ENABLE;
      cmatch_cnt_q  <= 2'd0;
      idle_cnt_q    <= 2'd0;
      prev_cfg_q    <= 16'h0000;
      ab_word_q     <= 16'h0000;
      lp_ability_q  <= 16'h0000;
      tx_cfg_q      <= 16'h0000;
      tmr_q         <= '0;
      xmit_q        <= 2'd1;
      page_rx_q     <= 1'b0;
      an_complete_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmatch_cnt_q  <= cmatch_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      prev_cfg_q    <= prev_cfg_d;
      ab_word_q     <= ab_word_d;
      lp_ability_q  <= lp_ability_d;
      tx_cfg_q      <= tx_cfg_d;
      tmr_q         <= tmr_d;
      xmit_q        <= xmit_d;
      page_rx_q     <= page_rx_d;
      an_complete_q <= an_complete_d;
    end
  end

  assign xmit_o        = xmit_q;
  assign tx_cfg_o      = tx_cfg_q;
  assign lp_ability_o  = lp_ability_q;
  assign page_rx_o     = page_rx_q;
  assign an_complete_o = an_complete_q;
  assign an_state_o    = state_q;

endmodule

// File: tb/tb_ippcsge_anctrl.sv
// Bench for ippcsge_anctrl: directed bring-up scenarios plus randomized partner traffic,
// checked every cycle against an event-history reference model.
module tb_ippcsge_anctrl;
  localparam int LT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        an_enable, an_restart;
  logic [15:0] mr_adv;
  logic [1:0]  xmit;
  logic [15:0] tx_cfg, lp_ability;
  logic        page_rx, an_complete;
  logic [2:0]  an_state;

  ippcsge_anctrl_if rx_if();

  ippcsge_anctrl #(.LINK_TIMER(LT), .TMR_W(5)) dut (
    .clk(clk), .rst(rst), .rx_if(rx_if.slave),
    .an_enable_i(an_enable), .an_restart_i(an_restart), .mr_adv_i(mr_adv),
    .xmit_o(xmit), .tx_cfg_o(tx_cfg), .lp_ability_o(lp_ability),
    .page_rx_o(page_rx), .an_complete_o(an_complete), .an_state_o(an_state)
  );

  always #4 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the last three RUDI events, the last /C/ word, and time since timer start.
  int          ev_t[3];   // 0 none, 1 /C/, 2 /I/ ; index 0 is newest
  logic [15:0] ev_w[3];
  logic [15:0] m_last = 16'h0, m_ab = 16'h0, m_lp = 16'h0, m_tx = 16'h0;
  int          m_st = 0, m_since = 0, m_xmit = 1;
  bit          m_page = 1'b0, m_cmp = 1'b0;

  task automatic model_step();
    bit abil, ackm, zero, idlem, inv, tdone, clr;
    int nst;
    logic [15:0] mk;
    if (rst) begin
      m_st = 0; m_last = 16'h0; m_since = 0; m_ab = 16'h0; m_lp = 16'h0; m_page = 1'b0;
      for (int i = 0; i < 3; i++) begin ev_t[i] = 0; ev_w[i] = 16'h0; end
    end else begin
      abil  = (ev_t[0] == 1) && (ev_t[1] == 1) && (ev_t[2] == 1) &&
              (((ev_w[0] ^ ev_w[1]) & 16'hBFFF) == 16'h0) && (((ev_w[1] ^ ev_w[2]) & 16'hBFFF) == 16'h0);
      mk    = m_last & 16'hBFFF;
      ackm  = abil && m_last[14];
      zero  = abil && (mk == 16'h0);
      idlem = (ev_t[0] == 2) && (ev_t[1] == 2) && (ev_t[2] == 2);
      inv   = rx_if.rudi_vld && (rx_if.rudi == 2'b11);
      tdone = (m_since >= LT - 1);
      clr   = 1'b0;
      nst   = m_st;
      if (!rx_if.sync || an_restart) nst = 0;
      else begin
        case (m_st)
          0: if (an_enable) begin nst = 1; clr = 1'b1; end else nst = 7;
          1: if (tdone) nst = 2;
          2: if (abil && !zero) begin nst = 3; m_ab = mk; end
          3: if (zero) nst = 0;
             else if (ackm && mk == m_ab) begin nst = 4; clr = 1'b1; m_lp = m_last; m_page = 1'b1; end
             else if (ackm) nst = 0;
          4: if (zero) nst = 0; else if (tdone) begin nst = 5; clr = 1'b1; end
          5: if (zero || inv) nst = 0; else if (tdone && idlem) nst = 6;
          6: if (abil || inv) nst = 0;
          default: if (an_enable) nst = 0;
        endcase
      end
      if (nst == 0) m_page = 1'b0;
      m_st = nst;
      if (rx_if.rudi_vld) begin
        if (rx_if.rudi == 2'b01 || rx_if.rudi == 2'b10) begin
          ev_t[2] = ev_t[1]; ev_w[2] = ev_w[1];
          ev_t[1] = ev_t[0]; ev_w[1] = ev_w[0];
          ev_t[0] = (rx_if.rudi == 2'b01) ? 1 : 2;
          ev_w[0] = rx_if.cfdata;
          if (rx_if.rudi == 2'b01) m_last = rx_if.cfdata;
        end else if (rx_if.rudi == 2'b11) begin
          for (int i = 0; i < 3; i++) ev_t[i] = 0;
        end
      end
      m_since = clr ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
    end
    m_xmit = (m_st == 5) ? 0 : ((m_st >= 6) ? 2 : 1);
    m_cmp  = (m_st == 6);
    if (m_st == 2)                 m_tx = mr_adv & 16'hBFFF;
    else if (m_st >= 3 && m_st <= 6) m_tx = mr_adv | 16'h4000;
    else                           m_tx = 16'h0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("an_state", 16'(an_state), 16'(m_st));
    check("xmit", 16'(xmit), 16'(m_xmit));
    check("tx_cfg", tx_cfg, m_tx);
    check("lp_ability", lp_ability, m_lp);
    check("page_rx", 16'(page_rx), 16'(m_page));
    check("an_complete", 16'(an_complete), 16'(m_cmp));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(int t, logic [15:0] w);
    rx_if.rudi_vld = 1'b1;
    rx_if.rudi     = (t == 1) ? 2'b01 : (t == 2) ? 2'b10 : (t == 3) ? 2'b11 : 2'b00;
    rx_if.cfdata   = w;
    tick();
    rx_if.rudi_vld = 1'b0;
    rx_if.cfdata   = 16'($urandom);
  endtask

  task automatic wait_state(int s, int budget, string name);
    int k;
    k = 0;
    while (int'(an_state) != s && k < budget) begin tick(); k++; end
    check(name, 16'(an_state), 16'(s));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  logic [15:0] words[6];
  int r, typ, rep, k;
  logic [15:0] w;

  initial begin
    words = '{16'h01A0, 16'h41A0, 16'h0000, 16'h4000, 16'h4020, 16'h0020};
    rx_if.sync = 1'b1; rx_if.rudi_vld = 1'b0; rx_if.rudi = 2'b00; rx_if.cfdata = 16'h0;
    an_enable = 1'b1; an_restart = 1'b0; mr_adv = 16'h01A0;
    do_reset();
    check("reset an_state", 16'(an_state), 16'd0);
    check("reset xmit", 16'(xmit), 16'd1);
    check("reset tx_cfg", tx_cfg, 16'h0000);
    wait_state(2, 40, "reach ABILITY_DETECT");
    check("ability tx_cfg", tx_cfg, 16'h01A0);

    repeat (3) send(1, 16'h01A0);
    repeat (3) send(1, 16'h41A0);
    wait_state(4, 10, "reach COMPLETE_ACK");
    wait_state(5, 30, "reach IDLE_DETECT");
    check("idle xmit", 16'(xmit), 16'd0);
    repeat (3) send(2, 16'h0);
    wait_state(6, 30, "reach LINK_OK");
    check("link lp_ability", lp_ability, 16'h41A0);
    check("model lp_ability", m_lp, 16'h41A0);
    check("link page_rx", 16'(page_rx), 16'd1);
    check("link xmit", 16'(xmit), 16'd2);
    check("link an_complete", 16'(an_complete), 16'd1);

    send(3, 16'h0);
    check("inv an_state", 16'(an_state), 16'd0);
    check("inv an_complete", 16'(an_complete), 16'd0);
    check("inv page_rx", 16'(page_rx), 16'd0);
    check("inv xmit", 16'(xmit), 16'd1);

    wait_state(2, 40, "re-reach ABILITY_DETECT");
    repeat (3) send(1, 16'h01A0);
    wait_state(3, 5, "reach ACK_DETECT");
    repeat (3) send(1, 16'h4020);
    wait_state(0, 5, "ack mismatch to AN_ENABLE");
    check("mismatch lp_ability", lp_ability, 16'h41A0);

    an_enable = 1'b0;
    do_reset();
    tick();
    check("disabled an_state", 16'(an_state), 16'd7);
    check("disabled xmit", 16'(xmit), 16'd2);
    an_enable = 1'b1;
    tick();
    check("enable an_state 0", 16'(an_state), 16'd0);
    tick();
    check("enable an_state 1", 16'(an_state), 16'd1);

    wait_state(2, 40, "third ABILITY_DETECT");
    mr_adv = 16'h01E0;
    tick();
    check("mr_adv follow", tx_cfg, 16'h01E0);
    repeat (3) send(1, 16'h01A0);
    repeat (3) send(1, 16'h41A0);
    wait_state(5, 40, "reach IDLE_DETECT again");
    rx_if.sync = 1'b0;
    tick();
    rx_if.sync = 1'b1;
    check("sync loss an_state", 16'(an_state), 16'd0);
    tick();
    check("after sync loss", 16'(an_state), 16'd1);
    k = 0;
    while (!(m_st == 1 && m_since == LT - 1) && k < 40) begin tick(); k++; end
    an_restart = 1'b1;
    tick();
    an_restart = 1'b0;
    check("restart beats tmr_done", 16'(an_state), 16'd0);
    tick();
    check("restart re-enters", 16'(an_state), 16'd1);
    repeat (10) tick();
    check("timer restarted", 16'(an_state), 16'd1);

    for (int b = 0; b < 600; b++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rx_if.sync = 1'b0; tick(); rx_if.sync = 1'b1;
      end else if (r < 5) begin
        an_restart = 1'b1; tick(); an_restart = 1'b0;
      end else if (r < 7) begin
        an_enable = ~an_enable; tick();
      end else if (r < 10) begin
        mr_adv = 16'($urandom); tick();
      end else if (r < 25) begin
        repeat ($urandom_range(1, 20)) tick();
      end else begin
        r = $urandom_range(0, 99);
        typ = (r < 60) ? 1 : (r < 88) ? 2 : (r < 96) ? 3 : 0;
        w = words[$urandom_range(0, 5)];
        rep = $urandom_range(1, 5);
        for (int j = 0; j < rep; j++) begin
          send(typ, w);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
